reg_wb_buffer: RTL and testbench

- Write-side initiator for the 32x`WORD register file; drives its w_reg/w_data/RegWrite port.
- Accepts writeback requests from the WB stage and buffers them in a small in-order FIFO.
- Drains at most one request per cycle into the register file through a registered output stage.
- Gives the ID stage a bypass lookup so reads observe writes that are still pending.

---
 rtl/reg_wb_buffer_if.sv | 32 +++
 rtl/reg_wb_buffer.sv | 137 +++++++++++++
 tb/tb_reg_wb_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_buffer_if.sv
// Writeback buffer bus: WB-stage request, register-file write port, ID-stage bypass lookup.
// slave is the buffer, master is whoever drives requests and looks up pending writes.
interface reg_wb_buffer_if #(
  parameter int WORD  = 64,
  parameter int DEPTH = 4
);
  logic                       wb_valid;
  logic [4:0]                 wb_reg;
  logic [WORD-1:0]            wb_data;
  logic                       wb_ready;
  logic                       drain_en;
  logic [4:0]                 w_reg;
  logic [WORD-1:0]            w_data;
  logic                       RegWrite;
  logic [4:0]                 fwd_reg1;
  logic [4:0]                 fwd_reg2;
  logic                       fwd_hit1;
  logic [WORD-1:0]            fwd_data1;
  logic                       fwd_hit2;
  logic [WORD-1:0]            fwd_data2;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  wb_valid, wb_reg, wb_data, drain_en, fwd_reg1, fwd_reg2,
    output wb_ready, w_reg, w_data, RegWrite, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );

  modport master (
    output wb_valid, wb_reg, wb_data, drain_en, fwd_reg1, fwd_reg2,
    input  wb_ready, w_reg, w_data, RegWrite, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
endinterface

// File: rtl/reg_wb_buffer.sv
// In-order writeback FIFO feeding the register-file write port through a registered stage,
// with a youngest-match bypass lookup for two ID read ports.
module reg_wb_fwd #(
  parameter int WORD  = 64,
  parameter int DEPTH = 4
) (
  input  logic [4:0]                  rd_reg,
  input  logic [DEPTH-1:0]            ord_vld,
  input  logic [DEPTH-1:0][4:0]       ord_reg,
  input  logic [DEPTH-1:0][WORD-1:0]  ord_data,
  input  logic                        out_vld,
  input  logic [4:0]                  out_reg,
  input  logic [WORD-1:0]             out_data,
  output logic                        hit,
  output logic [WORD-1:0]             data
);
  // Candidates are visited oldest first, so the last match wins (youngest).
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rd_reg != 5'd31) begin
      if (out_vld && out_reg == rd_reg) begin
        hit  = 1'b1;
        data = out_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (ord_vld[k] && ord_reg[k] == rd_reg) begin
          hit  = 1'b1;
          data = ord_data[k];
        end
      end
    end
  end
endmodule

module reg_wb_buffer #(
  parameter int WORD  = 64,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]      r;
    logic [WORD-1:0] d;
  } req_t;

  req_t              mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     cnt;
  logic              push, pop;
  logic              wen;
  logic [4:0]        wreg;
  logic [WORD-1:0]   wdata;

  // Ready is a pure function of occupancy; a same-edge pop never frees a slot for refill.
  assign bus.wb_ready = (cnt != CW'(DEPTH));
  assign push         = bus.wb_valid && bus.wb_ready && (bus.wb_reg != 5'd31);
  assign pop          = bus.drain_en && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      wen   <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (pop) begin
        wreg  <= mem[head].r;
        wdata <= mem[head].d;
        wen   <= 1'b1;
      end else begin
        wen   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{r: bus.wb_reg, d: bus.wb_data};
  end

  assign bus.w_reg    = wreg;
  assign bus.w_data   = wdata;
  assign bus.RegWrite = wen;
  assign bus.count    = cnt;

  // FIFO contents re-ordered by age: index 0 is the head (oldest).
  logic [DEPTH-1:0]            ord_vld;
  logic [DEPTH-1:0][4:0]       ord_reg;
  logic [DEPTH-1:0][WORD-1:0]  ord_data;

  always_comb begin
    ord_vld  = '0;
    ord_reg  = '0;
    ord_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ord_vld[k]  = CW'(k) < cnt;
      ord_reg[k]  = mem[head + AW'(k)].r;
      ord_data[k] = mem[head + AW'(k)].d;
    end
  end

  logic [1:0][4:0]       rd_reg;
  logic [1:0]            hit;
  logic [1:0][WORD-1:0]  hdat;

  assign rd_reg = {bus.fwd_reg2, bus.fwd_reg1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    reg_wb_fwd #(.WORD(WORD), .DEPTH(DEPTH)) u_fwd (
      .rd_reg   (rd_reg[g]),
      .ord_vld  (ord_vld),
      .ord_reg  (ord_reg),
      .ord_data (ord_data),
      .out_vld  (wen),
      .out_reg  (wreg),
      .out_data (wdata),
      .hit      (hit[g]),
      .data     (hdat[g])
    );
  end

  assign bus.fwd_hit1  = hit[0];
  assign bus.fwd_data1 = hdat[0];
  assign bus.fwd_hit2  = hit[1];
  assign bus.fwd_data2 = hdat[1];
endmodule

// File: tb/tb_reg_wb_buffer.sv
// Randomized and directed bench for reg_wb_buffer against a queue-based reference model.
module tb_reg_wb_buffer;
  localparam int WORD  = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_buffer_if #(.WORD(WORD), .DEPTH(DEPTH)) bus ();

  reg_wb_buffer #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]      r;
    logic [WORD-1:0] d;
  } ent_t;

  ent_t            q[$];
  logic            m_rw;
  logic [4:0]      m_wreg;
  logic [WORD-1:0] m_wdata;
  int              n_chk = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void mfwd(input logic [4:0] r, output logic hit, output logic [WORD-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (r == 5'd31) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].r == r) begin
        hit = 1'b1;
        d   = q[i].d;
        return;
      end
    end
    if (m_rw && m_wreg == r) begin
      hit = 1'b1;
      d   = m_wdata;
    end
  endfunction

  task automatic model_reset();
    q.delete();
    m_rw    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  task automatic model_step();
    ent_t e;
    logic rdy;
    rdy = (q.size() != DEPTH);
    if (bus.drain_en && q.size() != 0) begin
      e       = q.pop_front();
      m_rw    = 1'b1;
      m_wreg  = e.r;
      m_wdata = e.d;
    end else begin
      m_rw = 1'b0;
    end
    if (bus.wb_valid && rdy && bus.wb_reg != 5'd31) begin
      e.r = bus.wb_reg;
      e.d = bus.wb_data;
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    logic            h;
    logic [WORD-1:0] d;
    chk("wb_ready", bus.wb_ready, q.size() != DEPTH);
    chk("count",    bus.count,    q.size());
    chk("RegWrite", bus.RegWrite, m_rw);
    chk("w_reg",    bus.w_reg,    m_wreg);
    chk("w_data",   bus.w_data,   m_wdata);
    mfwd(bus.fwd_reg1, h, d);
    chk("fwd_hit1",  bus.fwd_hit1,  h);
    chk("fwd_data1", bus.fwd_data1, d);
    mfwd(bus.fwd_reg2, h, d);
    chk("fwd_hit2",  bus.fwd_hit2,  h);
    chk("fwd_data2", bus.fwd_data2, d);
  endtask

  // Drive at negedge, step the model at posedge, compare at the following negedge.
  task automatic cycle(input logic v, input logic [4:0] r, input logic [WORD-1:0] d,
                       input logic dr, input logic [4:0] f1, input logic [4:0] f2);
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = d;
    bus.drain_en = dr;
    bus.fwd_reg1 = f1;
    bus.fwd_reg2 = f2;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus.wb_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
    bus.drain_en = 1'b0;
    bus.fwd_reg1 = '0;
    bus.fwd_reg2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Single request, one-cycle drain latency
    cycle(1'b1, 5'd5, 64'h1234, 1'b1, 5'd5, 5'd0);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd0);
    chk("t1_regwrite", bus.RegWrite, 1'b1);
    chk("t1_w_reg",    bus.w_reg,    5'd5);
    chk("t1_w_data",   bus.w_data,   64'h1234);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd0);
    chk("t1_count", bus.count, 0);

    // XZR is swallowed
    cycle(1'b1, 5'd31, 64'hFFFF, 1'b1, 5'd31, 5'd31);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 5'd31);
    chk("t2_regwrite", bus.RegWrite, 1'b0);
    chk("t2_hit1",     bus.fwd_hit1, 1'b0);

    // Fill to full, fifth request refused, drain in order
    for (int i = 1; i <= 5; i++) cycle(1'b1, 5'(i), 64'(i * 16), 1'b0, 5'd3, 5'd5);
    chk("t3_count", bus.count, 4);
    chk("t3_ready", bus.wb_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 5'd1);
      chk("t3_order", bus.w_reg, 5'(i));
    end
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 5'd1);

    // Same register twice: youngest wins, then output stage, then gone
    cycle(1'b1, 5'd7, 64'hA, 1'b0, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 64'hB, 1'b0, 5'd7, 5'd7);
    chk("t4_data_b", bus.fwd_data1, 64'hB);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd7);
    chk("t4_after_pop1", bus.fwd_data1, 64'hB);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd7);
    chk("t4_out_stage", bus.fwd_hit1, 1'b1);
    cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd7, 5'd7);
    chk("t4_gone", bus.fwd_hit1, 1'b0);

    // Full with simultaneous pop and request: no same-cycle refill
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(10 + i), 64'(100 + i), 1'b0, 5'd9, 5'd10);
    cycle(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd10);
    chk("t5_no_accept", bus.fwd_hit1, 1'b0);
    cycle(1'b1, 5'd9, 64'h99, 1'b0, 5'd9, 5'd10);
    chk("t5_accept", bus.fwd_data1, 64'h99);
    repeat (6) cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd12);

    // Mid-cycle reset with pending entries and an active write
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(20 + i), 64'(200 + i), 1'b0, 5'd21, 5'd22);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd21, 5'd22);
    bus.drain_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_regwrite", bus.RegWrite, 1'b0);
    chk("t6_count",    bus.count,    0);
    chk("t6_w_reg",    bus.w_reg,    5'd0);
    chk("t6_w_data",   bus.w_data,   64'h0);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    repeat (3) cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd21, 5'd22);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r, f1, f2;
      logic       dr;
      r  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      f1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      f2 = 5'($urandom_range(0, 7));
      dr = ((n / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 3) != 0, r, {$urandom, $urandom}, dr, f1, f2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
